// File: rtl/jtframe_spitx_mc.sv
// jtframe_spitx_mc -- parametrised SPI master.
// Serialises DW-bit words on MOSI, assembles MISO into dout, drives active-low
// one-hot-mask selects. Programmable half-period (DIV clk), SPI mode (CPOL/CPHA),
// multi-word bursts under a held select (keep_i / stop_i).
// Optional feature macro: JTFRAME_SPITX_LSBF_EN adds lsb_first_i (LSB-first words).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, stop_i       transfer request (taken when ready_o) / end of held burst
//   keep_i, din_i         burst flag and word, latched at accept
//   cs_mask_i             selects to assert, latched only when accepted from idle
//   ready_o, busy_o       can accept start / select or transfer in progress
//   done_o, dout_o        one-cycle word-complete pulse / received word
//   spi_sck_o, spi_mosi_o, spi_miso_i, spi_ss_n_o   SPI bus
module jtframe_spitx_mc #(
  parameter int       DW   = 8,
  parameter int       CSN  = 3,
  parameter int       DIV  = 4,
  parameter bit       CPOL = 1'b0,
  parameter bit       CPHA = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic           keep_i,
  input  logic [DW-1:0]  din_i,
  input  logic [CSN-1:0] cs_mask_i,
`ifdef JTFRAME_SPITX_LSBF_EN
  input  logic           lsb_first_i,
`endif
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [DW-1:0]  dout_o,
  output logic           spi_sck_o,
  output logic           spi_mosi_o,
  input  logic           spi_miso_i,
  output logic [CSN-1:0] spi_ss_n_o
);
  localparam int CW = $clog2(DIV + 1);
  localparam int HW = $clog2(2 * DW);
  localparam logic [HW-1:0] LAST = HW'(2 * DW - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_HOLD, S_TRAIL, S_GAP} state_t;

  state_t         state_q;
  logic [CW-1:0]  div_q;
  logic [HW-1:0]  hcnt_q;     // index of the last SCK edge produced
  logic           pre_q;      // burst word: waiting DIV clk before its first edge
  logic           keep_q, lsbf_q;
  logic [DW-1:0]  tx_q, rx_q, dout_q;
  logic           sck_q, mosi_q, ready_q, busy_q, done_q;
  logic [CSN-1:0] ss_n_q;

  logic           lsb_in, smp, tx_bit_d, ld_bit_d, do_edge, do_load;
  logic [HW-1:0]  edge_d;
  logic [DW-1:0]  rx_d, tx_d, ld_sh_d;

  always_comb begin
    lsb_in = 1'b0;
`ifdef JTFRAME_SPITX_LSBF_EN
    lsb_in = lsb_first_i;
`endif
    edge_d   = (state_q == S_LEAD || pre_q) ? '0 : hcnt_q + HW'(1);
    // even edges are leading; CPHA selects which kind samples
    smp      = (edge_d[0] == CPHA);
    rx_d     = lsbf_q ? {spi_miso_i, rx_q[DW-1:1]} : {rx_q[DW-2:0], spi_miso_i};
    tx_bit_d = lsbf_q ? tx_q[0] : tx_q[DW-1];
    tx_d     = lsbf_q ? (tx_q >> 1) : (tx_q << 1);
    ld_bit_d = lsb_in ? din_i[0] : din_i[DW-1];
    ld_sh_d  = lsb_in ? (din_i >> 1) : (din_i << 1);
    do_edge  = (div_q == '0) &&
               ((state_q == S_LEAD) || (state_q == S_SHIFT && (pre_q || hcnt_q != LAST)));
    do_load  = start_i && ready_q &&
               ((state_q == S_IDLE) || (state_q == S_HOLD && !stop_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hcnt_q  <= '0;
      pre_q   <= 1'b0;
      keep_q  <= 1'b0;
      lsbf_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      done_q <= 1'b0;
      if (do_load) begin
        keep_q <= keep_i;
        lsbf_q <= lsb_in;
        if (CPHA) tx_q <= din_i;
        else begin
          // mode with sampling on the leading edge needs the first bit up front
          mosi_q <= ld_bit_d;
          tx_q   <= ld_sh_d;
        end
      end
      if (do_edge) begin
        sck_q  <= ~sck_q;
        hcnt_q <= edge_d;
        pre_q  <= 1'b0;
        if (smp) rx_q <= rx_d;
        else begin
          mosi_q <= tx_bit_d;
          tx_q   <= tx_d;
        end
      end
      case (state_q)
        S_IDLE: if (do_load) begin
          state_q <= S_LEAD;
          div_q   <= CW'(DIV - 1);
          ss_n_q  <= ~cs_mask_i;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
        S_LEAD: begin
          if (div_q == '0) begin
            state_q <= S_SHIFT;
            div_q   <= CW'(DIV - 1);
          end else div_q <= div_q - CW'(1);
        end
        S_SHIFT: begin
          if (div_q != '0) div_q <= div_q - CW'(1);
          else if (do_edge) div_q <= CW'(DIV - 1);
          else begin
            // final half-period elapsed: SCK is back at CPOL
            done_q  <= 1'b1;
            dout_q  <= rx_q;
            state_q <= keep_q ? S_HOLD : S_TRAIL;
            div_q   <= CW'(DIV - 1);
          end
        end
        S_HOLD: begin
          // ready rises one cycle after done; stop has priority over start
          if (stop_i) begin
            state_q <= S_TRAIL;
            div_q   <= CW'(DIV - 1);
            ready_q <= 1'b0;
          end else if (do_load) begin
            state_q <= S_SHIFT;
            pre_q   <= 1'b1;
            div_q   <= CW'(DIV - 1);
            ready_q <= 1'b0;
          end else ready_q <= 1'b1;
        end
        S_TRAIL: begin
          if (div_q == '0) begin
            ss_n_q  <= '1;
            state_q <= S_GAP;
            div_q   <= CW'(DIV - 1);
          end else div_q <= div_q - CW'(1);
        end
        S_GAP: begin
          if (div_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else div_q <= div_q - CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dout_o     = dout_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;
  assign spi_ss_n_o = ss_n_q;
endmodule

// File: tb/tb_jtframe_spitx_mc.sv
// Bench for jtframe_spitx_mc: mode-0 instance (MISO looped to MOSI) and
// mode-3 instance (MISO tied high), both DW=8, DIV=2.
module tb_jtframe_spitx_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st0, sp0, kp0, lsbf;
  logic [7:0] din0, do0;
  logic [2:0] m0, ss0;
  logic       rdy0, bsy0, dn0, sck0, mosi0;
  logic       st3, sp3, kp3;
  logic [7:0] din3, do3;
  logic [2:0] m3, ss3;
  logic       rdy3, bsy3, dn3, sck3, mosi3;
  logic       lsbf3;

  jtframe_spitx_mc #(.DW(8), .CSN(3), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(st0), .stop_i(sp0), .keep_i(kp0),
    .din_i(din0), .cs_mask_i(m0),
`ifdef JTFRAME_SPITX_LSBF_EN
    .lsb_first_i(lsbf),
`endif
    .ready_o(rdy0), .busy_o(bsy0), .done_o(dn0), .dout_o(do0),
    .spi_sck_o(sck0), .spi_mosi_o(mosi0), .spi_miso_i(mosi0), .spi_ss_n_o(ss0));

  jtframe_spitx_mc #(.DW(8), .CSN(3), .DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(st3), .stop_i(sp3), .keep_i(kp3),
    .din_i(din3), .cs_mask_i(m3),
`ifdef JTFRAME_SPITX_LSBF_EN
    .lsb_first_i(lsbf3),
`endif
    .ready_o(rdy3), .busy_o(bsy3), .done_o(dn3), .dout_o(do3),
    .spi_sck_o(sck3), .spi_mosi_o(mosi3), .spi_miso_i(1'b1), .spi_ss_n_o(ss3));

  int n_vec = 0, n_err = 0;
  int n_done0 = 0, rise0 = 0, rise3 = 0;
  logic [7:0] q0[$], q3[$];
  logic [7:0] cap0 = '0, cap3 = '0;
  logic sck0_p = 1'b0, sck3_p = 1'b1, burst_mon = 1'b0, ss_break = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard pop, MOSI capture on rising SCK, select watch -- all away from clk edge
  always @(negedge clk) begin
    if (dn0) begin
      n_done0++;
      if (q0.size() == 0) chk("sb0_unexpected_done", 32'd1, 32'd0);
      else chk("sb0_dout", {24'd0, do0}, {24'd0, q0.pop_front()});
    end
    if (dn3) begin
      if (q3.size() == 0) chk("sb3_unexpected_done", 32'd1, 32'd0);
      else chk("sb3_dout", {24'd0, do3}, {24'd0, q3.pop_front()});
    end
    if (sck0 && !sck0_p) begin cap0 = {cap0[6:0], mosi0}; rise0++; end
    if (sck3 && !sck3_p) begin cap3 = {cap3[6:0], mosi3}; rise3++; end
    sck0_p = sck0;
    sck3_p = sck3;
    if (burst_mon && ss0[0]) ss_break = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic send0(input logic [7:0] d, input logic [2:0] m, input logic k, input logic [7:0] e);
    din0 = d; m0 = m; kp0 = k; st0 = 1'b1;
    q0.push_back(e);
    tick;
    st0 = 1'b0;
  endtask

  // k = cycle index relative to the accept edge (call right after send0)
  task automatic wait_done0(output int k);
    k = 1;
    while (!dn0 && k < 200) begin tick; k++; end
    if (!dn0) chk("timeout_done0", 32'd0, 32'd1);
  endtask

  task automatic wait_idle0;
    int k = 0;
    while (!(rdy0 && !bsy0) && k < 200) begin tick; k++; end
    if (!(rdy0 && !bsy0)) chk("timeout_idle0", 32'd0, 32'd1);
  endtask

  initial begin
    int k, nd, n, r;
    logic p;
    rst = 1'b1; lsbf = 1'b0; lsbf3 = 1'b0;
    st0 = 0; sp0 = 0; kp0 = 0; din0 = 0; m0 = 0;
    st3 = 0; sp3 = 0; kp3 = 0; din3 = 0; m3 = 0;
    tick; tick;
    rst = 1'b0;
    // reset state
    chk("rst_ss_n", {29'd0, ss0}, 32'h7);
    chk("rst_sck0", {31'd0, sck0}, 32'd0);
    chk("rst_mosi", {31'd0, mosi0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_busy", {31'd0, bsy0}, 32'd0);
    chk("rst_done", {31'd0, dn0}, 32'd0);
    chk("rst_dout", {24'd0, do0}, 32'd0);
    chk("rst_sck3", {31'd0, sck3}, 32'd1);

    // 1: mode 0 loopback A5
    cap0 = '0; rise0 = 0;
    send0(8'hA5, 3'b001, 1'b0, 8'hA5);
    chk("t1_ss_n", {29'd0, ss0}, 32'h6);
    chk("t1_busy", {31'd0, bsy0}, 32'd1);
    chk("t1_ready", {31'd0, rdy0}, 32'd0);
    chk("t1_first_mosi", {31'd0, mosi0}, 32'd1);
    wait_done0(k);
    chk("t1_latency", k, 32'd35);
    chk("t1_mosi_bits", {24'd0, cap0}, 32'hA5);
    chk("t1_rises", rise0, 32'd8);
    chk("t1_sck_end", {31'd0, sck0}, 32'd0);
    wait_idle0;
    chk("t1_ss_idle", {29'd0, ss0}, 32'h7);

    // 2: mode 3, MISO high
    cap3 = '0; rise3 = 0;
    din3 = 8'h3C; m3 = 3'b001; kp3 = 1'b0; st3 = 1'b1;
    q3.push_back(8'hFF);
    tick;
    st3 = 1'b0;
    chk("t2_sck_lead", {31'd0, sck3}, 32'd1);
    k = 0;
    while (!dn3 && k < 200) begin tick; k++; end
    chk("t2_done_seen", {31'd0, dn3}, 32'd1);
    chk("t2_mosi_bits", {24'd0, cap3}, 32'h3C);
    chk("t2_rises", rise3, 32'd8);
    chk("t2_sck_end", {31'd0, sck3}, 32'd1);

    // 3: burst 53, 01, then stop
    send0(8'h53, 3'b001, 1'b1, 8'h53);
    burst_mon = 1'b1;
    wait_done0(k);
    chk("t3_ready_at_done", {31'd0, rdy0}, 32'd0);
    tick;
    chk("t3_ready_after_done", {31'd0, rdy0}, 32'd1);
    chk("t3_hold_sck", {31'd0, sck0}, 32'd0);
    send0(8'h01, 3'b100, 1'b1, 8'h01);
    k = 1;
    while (!sck0 && k < 50) begin tick; k++; end
    chk("t3_first_edge", k, 32'd3);
    wait_done0(k);
    tick;
    sp0 = 1'b1; tick; sp0 = 1'b0;
    chk("t3_trail1", {29'd0, ss0}, 32'h6);
    tick;
    chk("t3_trail2", {29'd0, ss0}, 32'h6);
    burst_mon = 1'b0;
    tick;
    chk("t3_gap_ss", {29'd0, ss0}, 32'h7);
    chk("t3_gap_busy", {31'd0, bsy0}, 32'd1);
    tick; tick;
    chk("t3_idle_ready", {31'd0, rdy0}, 32'd1);
    chk("t3_idle_busy", {31'd0, bsy0}, 32'd0);
    chk("t3_ss_held", {31'd0, ss_break}, 32'd0);

    // 4: reset at 4th SCK edge of 81
    send0(8'h81, 3'b001, 1'b0, 8'h81);
    p = sck0; n = 0; k = 0;
    while (n < 4 && k < 100) begin
      tick; k++;
      if (sck0 != p) begin n++; p = sck0; end
    end
    rst = 1'b1; tick; rst = 1'b0;
    q0.delete();
    chk("t4_ss_n", {29'd0, ss0}, 32'h7);
    chk("t4_sck", {31'd0, sck0}, 32'd0);
    chk("t4_mosi", {31'd0, mosi0}, 32'd0);
    chk("t4_ready", {31'd0, rdy0}, 32'd1);
    chk("t4_busy", {31'd0, bsy0}, 32'd0);
    chk("t4_dout", {24'd0, do0}, 32'd0);
    nd = n_done0;
    repeat (40) tick;
    chk("t4_no_done", n_done0 - nd, 32'd0);
    send0(8'h5A, 3'b010, 1'b0, 8'h5A);
    chk("t4_new_ss", {29'd0, ss0}, 32'h5);
    wait_done0(k);
    chk("t4_new_latency", k, 32'd35);
    wait_idle0;

    // 5: start while busy, stop in idle, stop & start in hold
    nd = n_done0;
    send0(8'hC3, 3'b100, 1'b0, 8'hC3);
    repeat (5) tick;
    din0 = 8'h11; st0 = 1'b1; tick; st0 = 1'b0;
    wait_idle0;
    chk("t5_one_done", n_done0 - nd, 32'd1);
    sp0 = 1'b1; tick; sp0 = 1'b0;
    chk("t5_stop_idle_ready", {31'd0, rdy0}, 32'd1);
    chk("t5_stop_idle_busy", {31'd0, bsy0}, 32'd0);
    chk("t5_stop_idle_ss", {29'd0, ss0}, 32'h7);
    send0(8'h96, 3'b001, 1'b1, 8'h96);
    wait_done0(k);
    tick;
    nd = n_done0; r = rise0;
    din0 = 8'h77; st0 = 1'b1; sp0 = 1'b1; tick; st0 = 1'b0; sp0 = 1'b0;
    chk("t5_trail_ss", {29'd0, ss0}, 32'h6);
    chk("t5_trail_ready", {31'd0, rdy0}, 32'd0);
    wait_idle0;
    repeat (40) tick;
    chk("t5_no_word", n_done0 - nd, 32'd0);
    chk("t5_no_sck", rise0 - r, 32'd0);
    chk("t5_queue", q0.size(), 32'd0);

`ifdef JTFRAME_SPITX_LSBF_EN
    // 6: LSB first
    lsbf = 1'b1; cap0 = '0;
    send0(8'h01, 3'b001, 1'b0, 8'h01);
    chk("t6_first_mosi", {31'd0, mosi0}, 32'd1);
    wait_done0(k);
    chk("t6_mosi_bits", {24'd0, cap0}, 32'h80);
    wait_idle0;
    lsbf = 1'b0;
`endif

    tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
